// File: rtl/bch_t12_parity_engine.sv
// Streaming DVB-S2 normal-frame BCH encoder (t=12, 192 parity bits), one payload byte per clk_1x.
// Optional payload length check is built only when BCH_FRAME_LEN_CHECK_EN is defined.
module bch_t12_parity_engine #(
  parameter int ROM_BASE = 0,
  parameter int NUM_ROWS = 8,
  parameter int K_BYTES  = 4026
) (
  input  logic         clk_1x,
  input  logic         rst,
  output logic         rom_rd_en,
  output logic [4:0]   rom_rdaddr,
  input  logic [191:0] rom_rd_q,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   in_data,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [7:0]   out_data,
  output logic         out_last,
  output logic         len_err,
  output logic         init_done,
  output logic [1:0]   state_dbg
);
  // Handshake: a beat moves on a clk_1x edge where valid and ready are both high; valid never
  // depends on ready, and a presented output beat (valid/data/last) holds until it is taken.

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2
  } state_t;

  localparam int            CW        = $clog2(NUM_ROWS + 1);
  localparam logic [CW-1:0] LOAD_END  = CW'(NUM_ROWS);
  localparam int            PAR_BYTES = 24;

  state_t        state_q, state_d;
  logic [CW-1:0] load_cnt_q;
  logic [191:0]  cache_q [NUM_ROWS];
  logic [191:0]  par_q;
  logic [191:0]  par_upd;
  logic [191:0]  par_shift;
  logic [4:0]    par_idx_q;
  logic [7:0]    fb;
  logic          out_free;
  logic          accept;
  logic          par_emit;
  logic          last_pop;
  logic          load_done;

  assign out_free  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign last_pop  = (state_q == ST_PARITY) && out_valid && out_ready && out_last;
  assign state_dbg = state_q;

  // State register
  always_ff @(posedge clk_1x) begin
    if (rst) state_q <= ST_LOAD;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_LOAD:   if (load_done)          state_d = ST_DATA;
      ST_DATA:   if (accept && in_last)  state_d = ST_PARITY;
      ST_PARITY: if (last_pop)           state_d = ST_DATA;
      default:                           state_d = ST_LOAD;
    endcase
  end

  // Output / strobe logic
  always_comb begin
    rom_rd_en  = 1'b0;
    rom_rdaddr = '0;
    in_ready   = 1'b0;
    par_emit   = 1'b0;
    load_done  = 1'b0;
    case (state_q)
      ST_LOAD: begin
        rom_rd_en = !rst && (load_cnt_q < LOAD_END);
        if (rom_rd_en) rom_rdaddr = 5'(ROM_BASE) + 5'(load_cnt_q);
        load_done = (load_cnt_q == LOAD_END);
      end
      ST_DATA:   in_ready = out_free;
      ST_PARITY: par_emit = out_free && (par_idx_q < 5'(PAR_BYTES));
      default: ;
    endcase
  end

  // ROM data trails rd_en by one cycle, so count value k+1 captures row k.
  always_ff @(posedge clk_1x) begin
    if (rst) begin
      load_cnt_q <= '0;
      init_done  <= 1'b0;
      for (int i = 0; i < NUM_ROWS; i++) cache_q[i] <= '0;
    end else if (state_q == ST_LOAD) begin
      if (load_cnt_q != LOAD_END) load_cnt_q <= load_cnt_q + CW'(1);
      for (int i = 0; i < NUM_ROWS; i++)
        if (load_cnt_q == CW'(i + 1)) cache_q[i] <= rom_rd_q;
      if (load_done) init_done <= 1'b1;
    end
  end

  // Byte-parallel remainder update: feedback bit i selects x^(192+i) mod g(x).
  always_comb begin
    fb      = par_q[191:184] ^ in_data;
    par_upd = par_q << 8;
    for (int i = 0; i < NUM_ROWS; i++)
      if (fb[i]) par_upd = par_upd ^ cache_q[i];
  end

  assign par_shift = par_q << {par_idx_q, 3'b000};

  always_ff @(posedge clk_1x) begin
    if (rst) begin
      par_q     <= '0;
      par_idx_q <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (accept) begin
      par_q     <= par_upd;
      out_data  <= in_data;
      out_valid <= 1'b1;
      out_last  <= 1'b0;
    end else if (par_emit) begin
      out_data  <= par_shift[191:184];
      out_valid <= 1'b1;
      out_last  <= (par_idx_q == 5'(PAR_BYTES - 1));
      par_idx_q <= par_idx_q + 5'd1;
    end else begin
      if (out_ready) out_valid <= 1'b0;
      if (last_pop) begin
        par_q     <= '0;
        par_idx_q <= '0;
      end
    end
  end

`ifdef BCH_FRAME_LEN_CHECK_EN
  logic [12:0] byte_cnt_q;
  logic [12:0] byte_num;

  assign byte_num = byte_cnt_q + 13'd1;

  always_ff @(posedge clk_1x) begin
    if (rst) begin
      byte_cnt_q <= '0;
      len_err    <= 1'b0;
    end else begin
      len_err <= accept && ((in_last && (byte_num != 13'(K_BYTES))) ||
                            (!in_last && (byte_num == 13'(K_BYTES))));
      if (accept) byte_cnt_q <= in_last ? 13'd0 : byte_num;
    end
  end
`else
  assign len_err = 1'b0;
`endif

endmodule

// File: tb/tb_bch_t12_parity_engine.sv
// Bench for bch_t12_parity_engine: ROM built from g(x), bit-serial division model, byte scoreboard.
module tb_bch_t12_parity_engine;
  localparam int ROM_BASE = 0;
  localparam int NUM_ROWS = 8;
  localparam int K_BYTES  = 4026;
`ifdef BCH_FRAME_LEN_CHECK_EN
  localparam bit LEN_CHK = 1'b1;
`else
  localparam bit LEN_CHK = 1'b0;
`endif

  logic         clk_1x;
  logic         rst;
  logic         rom_rd_en;
  logic [4:0]   rom_rdaddr;
  logic [191:0] rom_rd_q;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   in_data;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [7:0]   out_data;
  logic         out_last;
  logic         len_err;
  logic         init_done;
  logic [1:0]   state_dbg;

  bch_t12_parity_engine #(
    .ROM_BASE(ROM_BASE), .NUM_ROWS(NUM_ROWS), .K_BYTES(K_BYTES)
  ) dut (
    .clk_1x(clk_1x), .rst(rst),
    .rom_rd_en(rom_rd_en), .rom_rdaddr(rom_rdaddr), .rom_rd_q(rom_rd_q),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .len_err(len_err), .init_done(init_done), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk_1x = 1'b0;
  always #5 clk_1x = ~clk_1x;

  int           checks = 0;
  int           errors = 0;
  int           par_seen = 0;
  int           len_err_cnt = 0;
  int           bubble_cnt = 0;
  int           rdy_pct = 100;
  bit           mon_en = 1'b0;
  bit           prev_stall = 1'b0;
  logic [8:0]   prev_word;
  logic [191:0] rom_mem [32];
  logic [192:0] g_poly;
  logic [7:0]   frame_q [$];
  logic [9:0]   exp_q [$];

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // g(x) = product of the twelve degree-16 minimal polynomials; ROM row i = x^(192+i) mod g(x)
  task automatic build_tables();
    logic [16:0]  gm [12];
    logic [192:0] prod;
    logic [191:0] r;
    gm = '{17'h1002D, 17'h10173, 17'h10FBD, 17'h15A55, 17'h11F2F, 17'h1F7B5,
           17'h1AF65, 17'h17367, 17'h10EA1, 17'h175A7, 17'h13A2D, 17'h11AE3};
    g_poly = 193'd1;
    for (int m = 0; m < 12; m++) begin
      prod = '0;
      for (int i = 0; i <= 16; i++)
        if (gm[m][i]) prod = prod ^ (g_poly << i);
      g_poly = prod;
    end
    r = g_poly[191:0];
    for (int i = 0; i < 32; i++) begin
      rom_mem[(ROM_BASE + i) % 32] = r;
      r = {r[190:0], 1'b0} ^ (r[191] ? g_poly[191:0] : 192'd0);
    end
  endtask

  // remainder of (message * x^192) by long division, one message bit at a time
  function automatic logic [191:0] model_parity();
    logic [191:0] r;
    logic         b;
    r = '0;
    foreach (frame_q[j])
      for (int k = 7; k >= 0; k--) begin
        b = r[191] ^ frame_q[j][k];
        r = {r[190:0], 1'b0};
        if (b) r = r ^ g_poly[191:0];
      end
    return r;
  endfunction

  // next-state ROM: registered read, junk when not enabled
  always @(posedge clk_1x) begin
    if (rom_rd_en) rom_rd_q <= rom_mem[rom_rdaddr];
    else           rom_rd_q <= {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
  end

  always @(negedge clk_1x) out_ready = (int'($urandom_range(99, 0)) < rdy_pct);

  always @(negedge clk_1x) if (len_err === 1'b1) len_err_cnt++;

  // scoreboard
  always @(negedge clk_1x) begin
    logic [9:0] e;
    #1;
    if (mon_en) begin
      if (prev_stall) begin
        chk("hold_valid", out_valid, 1'b1);
        chk("hold_word", {out_last, out_data}, prev_word);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("spurious_out", out_valid, 1'b0);
        else begin
          e = exp_q.pop_front();
          chk("out_byte", {out_last, out_data}, e[8:0]);
          if (e[9]) par_seen++;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_word  = {out_last, out_data};
    end else prev_stall = 1'b0;
  end

  // driver tasks
  task automatic make_frame(input int len, input int kind);
    frame_q.delete();
    for (int j = 0; j < len; j++)
      case (kind)
        0:       frame_q.push_back(8'h00);
        1:       frame_q.push_back(8'($urandom_range(255, 0)));
        2:       frame_q.push_back(8'h80);
        default: frame_q.push_back(8'h01);
      endcase
  endtask

  task automatic push_expected(input logic [191:0] par);
    logic [191:0] t;
    t = par;
    foreach (frame_q[j]) exp_q.push_back({2'b00, frame_q[j]});
    for (int p = 0; p < 24; p++) begin
      exp_q.push_back({1'b1, (p == 23), t[191:184]});
      t = t << 8;
    end
  endtask

  task automatic send_frame(input int gap_pct, input bit garbage);
    int wait_cnt;
    for (int j = 0; j < frame_q.size(); j++) begin
      @(negedge clk_1x);
      if (gap_pct > 0 && int'($urandom_range(99, 0)) < gap_pct) begin
        in_valid = 1'b0;
        @(negedge clk_1x);
      end
      in_valid = 1'b1;
      in_data  = frame_q[j];
      in_last  = (j == frame_q.size() - 1);
      #1;
      wait_cnt = 0;
      while (!in_ready && wait_cnt < 200) begin
        bubble_cnt++;
        @(negedge clk_1x);
        #1;
        wait_cnt++;
      end
      if (wait_cnt >= 200) begin
        chk("in_ready_timeout", in_ready, 1'b1);
        break;
      end
      @(posedge clk_1x);
    end
    @(negedge clk_1x);
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (garbage) begin
      for (int c = 0; c < 5; c++) begin
        in_valid = 1'b1;
        in_data  = 8'($urandom_range(255, 0));
        in_last  = 1'($urandom_range(1, 0));
        #1;
        chk("in_ready_in_parity", in_ready, 1'b0);
        @(negedge clk_1x);
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 30000) begin
      @(negedge clk_1x);
      n++;
    end
    chk(tag, exp_q.size(), 0);
    #2;
    chk("idle_out_valid", out_valid, 1'b0);
  endtask

  task automatic check_load();
    int cyc;
    int reads;
    cyc   = 0;
    reads = 0;
    #1;
    while (!init_done && cyc < 20) begin
      chk("in_ready_load", in_ready, 1'b0);
      if (rom_rd_en) begin
        chk("rom_rdaddr", rom_rdaddr, ROM_BASE + reads);
        reads++;
      end
      @(posedge clk_1x);
      #1;
      cyc++;
    end
    chk("init_cycles", cyc, 9);
    chk("rom_reads", reads, NUM_ROWS);
    chk("in_ready_at_init", in_ready, 1'b1);
  endtask

  task automatic run_frame(input int len, input int kind, input int rdy, input int gap,
                           input bit garbage, input string tag);
    make_frame(len, kind);
    if (kind == 2)      push_expected(rom_mem[ROM_BASE + 7]);
    else if (kind == 3) push_expected(rom_mem[ROM_BASE]);
    else                push_expected(model_parity());
    rdy_pct     = rdy;
    len_err_cnt = 0;
    bubble_cnt  = 0;
    send_frame(gap, garbage);
    wait_drain(tag);
    chk("len_err_pulses", len_err_cnt, (LEN_CHK && len != K_BYTES) ? 1 : 0);
  endtask

  initial begin
    int n;
    build_tables();
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    in_last  = 1'b0;
    repeat (3) @(posedge clk_1x);
    @(negedge clk_1x);
    #1;
    chk("rst_rom_rd_en", rom_rd_en, 1'b0);
    chk("rst_rom_rdaddr", rom_rdaddr, 0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_len_err", len_err, 1'b0);
    chk("rst_init_done", init_done, 1'b0);
    @(negedge clk_1x);
    rst = 1'b0;
    check_load();
    mon_en = 1'b1;

    run_frame(K_BYTES, 0, 100, 0, 1'b0, "drain_zero");
    chk("zero_in_ready_bubbles", bubble_cnt, 0);
    run_frame(1, 2, 100, 0, 1'b0, "drain_byte80");
    run_frame(1, 3, 100, 0, 1'b0, "drain_byte01");
    run_frame(K_BYTES, 1, 50, 10, 1'b1, "drain_rand_a");
    run_frame(K_BYTES, 1, 50, 10, 1'b0, "drain_rand_b");

    // reset in the middle of the parity tail
    make_frame(20, 1);
    push_expected(model_parity());
    rdy_pct  = 100;
    par_seen = 0;
    send_frame(0, 1'b0);
    n = 0;
    while (par_seen < 10 && n < 500) begin
      @(negedge clk_1x);
      #2;
      n++;
    end
    chk("reach_parity_p10", par_seen >= 10, 1'b1);
    mon_en = 1'b0;
    rst    = 1'b1;
    @(posedge clk_1x);
    #1;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_out_last", out_last, 1'b0);
    chk("midrst_init_done", init_done, 1'b0);
    chk("midrst_in_ready", in_ready, 1'b0);
    chk("midrst_rom_rd_en", rom_rd_en, 1'b0);
    @(negedge clk_1x);
    rst = 1'b0;
    exp_q.delete();
    check_load();
    mon_en = 1'b1;
    run_frame(30, 1, 50, 10, 1'b0, "drain_post_rst");

    run_frame(K_BYTES - 1, 1, 100, 0, 1'b0, "drain_short");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bch_t12_parity_engine.md
Name: bch_t12_parity_engine

Overview:
- Streaming DVB-S2 normal-frame BCH encoder core (t=12, 192 parity bits).
- Sits directly downstream of the t12 next-state ROM. At start-up it drives that ROM's rd_en/rdaddr and caches NUM_ROWS 192-bit remainder rows.
- Then processes one payload byte per cycle and appends 24 parity bytes to each frame, feeding the BBFRAME-to-LDPC path.

Parameters:
- ROM_BASE, 0: ROM address of remainder row 0. Row i = x^(192+i) mod g(x).
- NUM_ROWS, 8: rows cached; equals the data byte width.
- K_BYTES, 4026: expected payload bytes per frame (Kbch 32208/8); used only by the optional check.

Ports:
- clk_1x  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- rom_rd_en  out  1  read strobe to the next-state ROM.
- rom_rdaddr  out  5  ROM row address.
- rom_rd_q  in  192  ROM data, valid the cycle after rom_rd_en.
- in_valid  in  1  payload byte valid.
- in_ready  out  1  engine accepts a byte.
- in_data  in  8  payload byte, MSB is the first bit on air.
- in_last  in  1  last payload byte of the frame.
- out_valid  out  1  output byte valid.
- out_ready  in  1  downstream accepts.
- out_data  out  8  payload passthrough, then parity.
- out_last  out  1  marks the final parity byte.
- len_err  out  1  one-cycle pulse on a frame-length mismatch (optional feature).
- init_done  out  1  row cache loaded.

Behaviour:
- Clock and reset: one clock, clk_1x. Reset rst is synchronous and active-high. On rst:
  - state=LOAD, parity reg=0, row cache=0, load counter=0.
  - rom_rd_en=0, rom_rdaddr=0, in_ready=0, out_valid=0, out_data=0, out_last=0, len_err=0, init_done=0.
- States: LOAD, DATA, PARITY.
- LOAD:
  - Cycles k=0..NUM_ROWS-1: rom_rd_en=1, rom_rdaddr=ROM_BASE+k.
  - Cycle k+1: rom_rd_q is captured into cache[k].
  - After capturing cache[NUM_ROWS-1] (NUM_ROWS+1 cycles after reset release): rom_rd_en=0, init_done=1 (stays 1 until reset), go to DATA.
  - in_ready=0 throughout LOAD.
- DATA:
  - in_ready = !out_valid | out_ready (single output register; no bubble under continuous flow).
  - Accept = in_valid & in_ready.
  - On accept:
    - f = parity[191:184] ^ in_data.
    - parity <= (parity<<8) ^ XOR over i=0..7 of (f[i] ? cache[i] : 0).
    - out_data <= in_data, out_valid <= 1, out_last <= 0.
  - If in_last is accepted, go to PARITY with a parity byte index p=0.
  - Latency in->out: 1 cycle.
- PARITY:
  - in_ready=0.
  - When the output register is free (!out_valid | out_ready): out_data <= parity[191-8p -: 8], out_valid <= 1, out_last <= (p==23), then p++.
  - When the byte with out_last=1 is consumed: parity <= 0, return to DATA.
  - Exactly 24 parity bytes per frame, MSB first.
- Output hold: out_valid, out_data and out_last hold stable while out_valid & !out_ready.
- Boundaries:
  - A 1-byte frame is legal.
  - Back-to-back frames: the first byte of the next frame can be accepted the cycle after the last parity byte is consumed.
  - in_valid during LOAD or PARITY is ignored (in_ready=0).
  - rst mid-frame or mid-parity: frame is abandoned and the engine re-enters LOAD. The ROM is re-read (NUM_ROWS+1 cycles) and outputs clear as listed above.
  - The parity reg is never cleared in DATA except after a frame completes.

Optional Feature:
- Macro BCH_FRAME_LEN_CHECK_EN.
- Defined:
  - A 13-bit byte counter increments per accepted payload byte and resets when in_last is accepted.
  - If in_last is accepted at a count != K_BYTES, or the count reaches K_BYTES without in_last, len_err pulses high for 1 cycle.
  - Data and parity flow are unaffected.
  - The counter clears on rst.
- Not defined: len_err is tied to 0 and no counter logic is built.

Test Plan:
- Reset release -> rom_rdaddr 0..7 on rom_rd_en across 8 cycles; init_done=1 exactly 9 cycles after rst drops; in_ready first high the same cycle.
- 4026 bytes of 0x00 with continuous out_ready=1 -> 4026 zero bytes out, then 24 bytes of 0x00, out_last only on the 24th; no in_ready bubble during payload.
- Single-byte frame 0x80 -> out 0x80, then 24 parity bytes equal to ROM row ROM_BASE+7 (MSB first). Repeat with 0x01 -> parity equals row ROM_BASE+0.
- Random 4026-byte frame, out_ready toggled at random 50% -> output stream byte-identical to the software BCH model. Output holds during stalls; second frame starts with parity cleared.
- rst asserted for 1 cycle at parity byte p=10 -> out_valid=0 next cycle, LOAD re-run (8 ROM reads). The next frame's parity matches the golden model.
- BCH_FRAME_LEN_CHECK_EN defined, frame of 4025 bytes -> len_err pulses 1 cycle when in_last is accepted; 4026-byte frame -> no pulse.
